arith_cmd_issuer: RTL and testbench

- Command-side front end for sync_arith_unit_29. Accepts (A, B, op) commands on a valid/ready interface and buffers them in a small FIFO.
- Issues one command at a time to the arithmetic unit and holds its inputs stable for the op-specific latency.
- Captures o_result/o_status and returns them on a valid/ready response port with a sequence tag.
- Sits directly upstream of the arithmetic unit and also consumes its outputs.

---
 rtl/arith_pkg.sv | 30 +++
 rtl/arith_cmd_issuer_if.sv | 36 +++
 rtl/arith_cmd_fifo.sv | 57 +++++
 rtl/arith_cmd_issuer.sv | 129 ++++++++++++
 tb/tb_arith_cmd_issuer.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic command issuer: op codes, status bit
// positions, the queued command record and the issue FSM states.
package arith_pkg;

    localparam int ARITH_W = 32;

    localparam logic [3:0] OP_BITWISE_SHIFT = 4'd0;
    localparam logic [3:0] OP_COMPARE_AS    = 4'd1;
    localparam logic [3:0] OP_DIVIDE        = 4'd2;
    localparam logic [3:0] OP_ZM_TO_U2      = 4'd3;

    localparam int ERROR      = 3;
    localparam int NOT_EVEN_1 = 2;
    localparam int ZEROS      = 1;
    localparam int OVERFLOW   = 0;

    typedef struct packed {
        logic [ARITH_W-1:0] a;
        logic [ARITH_W-1:0] b;
        logic [3:0]         op;
        logic [3:0]         tag;
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

endpackage

// File: rtl/arith_cmd_issuer_if.sv
// Command, arithmetic-unit and response signals of the issuer bundled together;
// slave is the issuer side, master is the side that feeds and drains it.
interface arith_cmd_issuer_if #(
    parameter int M = 32
);
    logic         i_cmd_valid;
    logic         o_cmd_ready;
    logic [M-1:0] i_cmd_a;
    logic [M-1:0] i_cmd_b;
    logic [3:0]   i_cmd_op;
    logic [M-1:0] o_alu_a;
    logic [M-1:0] o_alu_b;
    logic [3:0]   o_alu_op;
    logic [M-1:0] i_alu_result;
    logic [3:0]   i_alu_status;
    logic         o_res_valid;
    logic         i_res_ready;
    logic [M-1:0] o_res_data;
    logic [3:0]   o_res_status;
    logic [3:0]   o_res_tag;
    logic         o_busy;

    modport slave (
        input  i_cmd_valid, i_cmd_a, i_cmd_b, i_cmd_op,
        input  i_alu_result, i_alu_status, i_res_ready,
        output o_cmd_ready, o_alu_a, o_alu_b, o_alu_op,
        output o_res_valid, o_res_data, o_res_status, o_res_tag, o_busy
    );

    modport master (
        output i_cmd_valid, i_cmd_a, i_cmd_b, i_cmd_op,
        output i_alu_result, i_alu_status, i_res_ready,
        input  o_cmd_ready, o_alu_a, o_alu_b, o_alu_op,
        input  o_res_valid, o_res_data, o_res_status, o_res_tag, o_busy
    );
endinterface

// File: rtl/arith_cmd_fifo.sv
// Show-ahead FIFO: the head entry is always visible on dout while not empty.
// Full/empty come from the registered count, so a pop never frees room for a same-cycle push.
module arith_cmd_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     i_reset,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/arith_cmd_issuer.sv
// Command-side front end for the arithmetic unit: queues commands, issues one at a
// time with an op-dependent hold window, and returns the captured result with a tag.
module arith_cmd_issuer
    import arith_pkg::*;
#(
    parameter int M       = ARITH_W,
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 3,
    parameter int DIV_LAT = 35
) (
    input logic               clk,
    input logic               i_reset,
    arith_cmd_issuer_if.slave bus
);
    localparam int MAX_LAT = (ALU_LAT > DIV_LAT) ? ALU_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT) + 1;
    localparam int PW      = $clog2(DEPTH);

    state_t        state;
    state_t        next_state;
    cmd_t          new_cmd;
    cmd_t          head;
    cmd_t          issue;
    logic          fifo_full;
    logic          fifo_empty;
    logic [PW:0]   count;
    logic          push;
    logic          launch;
    logic          capture;
    logic [CW-1:0] wait_cnt;
    logic [3:0]    tag_cnt;
    logic          res_valid;
    logic [M-1:0]  res_data;
    logic [3:0]    res_status;
    logic [3:0]    res_tag;

    assign bus.o_cmd_ready = !fifo_full;
    assign push            = bus.i_cmd_valid && !fifo_full;
    assign new_cmd         = '{a: bus.i_cmd_a, b: bus.i_cmd_b, op: bus.i_cmd_op, tag: tag_cnt};

    // A launch happens from idle, or straight out of a consumed response so
    // back-to-back commands never spend a cycle in S_IDLE.
    assign launch  = !fifo_empty &&
                     ((state == S_IDLE) || ((state == S_RESP) && bus.i_res_ready));
    assign capture = (state == S_EXEC) && (wait_cnt == '0);

    arith_cmd_fifo #(
        .W     ($bits(cmd_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .i_reset (i_reset),
        .push    (push),
        .din     (new_cmd),
        .pop     (launch),
        .dout    (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (count)
    );

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (!fifo_empty) next_state = S_EXEC;
            S_EXEC:  if (wait_cnt == '0) next_state = S_RESP;
            S_RESP:  if (bus.i_res_ready) next_state = fifo_empty ? S_IDLE : S_EXEC;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        bus.o_alu_a  = '0;
        bus.o_alu_b  = '0;
        bus.o_alu_op = OP_ZM_TO_U2;
        bus.o_busy   = (state != S_IDLE) || (count != '0);
        if (state == S_EXEC) begin
            bus.o_alu_a  = issue.a;
            bus.o_alu_b  = issue.b;
            bus.o_alu_op = issue.op;
        end
    end

    // The wait counter is loaded with LAT-1 at launch, so capture lands exactly
    // LAT edges after the launch edge.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            issue      <= '0;
            wait_cnt   <= '0;
            tag_cnt    <= '0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_status <= '0;
            res_tag    <= '0;
        end else begin
            if (push) begin
                tag_cnt <= tag_cnt + 1'b1;
            end
            if (launch) begin
                issue    <= head;
                wait_cnt <= (head.op == OP_DIVIDE) ? CW'(DIV_LAT - 1) : CW'(ALU_LAT - 1);
            end else if ((state == S_EXEC) && (wait_cnt != '0)) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
            if (capture) begin
                res_valid  <= 1'b1;
                res_data   <= bus.i_alu_result;
                res_status <= bus.i_alu_status;
                res_tag    <= issue.tag;
            end else if ((state == S_RESP) && bus.i_res_ready) begin
                res_valid  <= 1'b0;
            end
        end
    end

    assign bus.o_res_valid  = res_valid;
    assign bus.o_res_data   = res_data;
    assign bus.o_res_status = res_status;
    assign bus.o_res_tag    = res_tag;

endmodule

// File: tb/tb_arith_cmd_issuer.sv
// Scoreboard bench for arith_cmd_issuer: a behavioural arithmetic unit answers the
// issued commands, and a negedge monitor compares every response against a queue.
module tb_arith_cmd_issuer;
    import arith_pkg::*;

    localparam int M       = 32;
    localparam int DEPTH   = 4;
    localparam int ALU_LAT = 3;
    localparam int DIV_LAT = 35;

    typedef struct {
        logic [M-1:0] data;
        logic [3:0]   status;
        logic [3:0]   tag;
        logic [3:0]   op;
    } exp_t;

    logic   clk = 1'b0;
    logic   i_reset;
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     ready_mode = 1;
    logic [3:0] tag_model = 4'd0;
    exp_t   exp_q[$];

    arith_cmd_issuer_if #(.M(M)) bus();

    arith_cmd_issuer #(
        .M       (M),
        .DEPTH   (DEPTH),
        .ALU_LAT (ALU_LAT),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .clk     (clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Behavioural arithmetic unit: logical right shift, signed compare, divide,
    // sign-magnitude to two's complement; unknown ops and divide by zero flag ERROR.
    function automatic logic [M+3:0] aluModel(input logic [M-1:0] a, input logic [M-1:0] b,
                                              input logic [3:0] op);
        logic [M-1:0] r;
        logic [3:0]   s;
        r = '0;
        s = '0;
        case (op)
            4'd0:    r = a >> b[4:0];
            4'd1:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd2:    if (b == 0) s[ERROR] = 1'b1; else r = a / b;
            4'd3:    r = a[M-1] ? -({1'b0, a[M-2:0]}) : a;
            default: s[ERROR] = 1'b1;
        endcase
        s[ZEROS]      = (r == 0);
        s[NOT_EVEN_1] = ^r;
        return {s, r};
    endfunction

    always_comb {bus.i_alu_status, bus.i_alu_result} = aluModel(bus.o_alu_a, bus.o_alu_b, bus.o_alu_op);

    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       bus.i_res_ready = 1'b0;
            1:       bus.i_res_ready = 1'b1;
            default: bus.i_res_ready = 1'($urandom_range(0, 1));
        endcase
    end

    function automatic void checkOutput(input string name, input logic [63:0] act,
                                        input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, req, cyc);
        end
    endfunction

    // Response monitor: pops on each rising o_res_valid, checks data, hold window
    // and latency, and checks the response stays frozen while it is back-pressured.
    logic         prev_valid, prev_ready, prev_alu_idle, hold_ok, alu_idle;
    logic [M+7:0] prev_resp;
    logic [M*2+3:0] held;
    int           launch_cyc;
    exp_t         e;

    always @(negedge clk) begin
        if (!i_reset) begin
            prev_valid    = 1'b0;
            prev_ready    = 1'b0;
            prev_alu_idle = 1'b1;
            hold_ok       = 1'b1;
        end else begin
            alu_idle = (bus.o_alu_a == 0) && (bus.o_alu_b == 0) && (bus.o_alu_op == 4'd3);
            if (!alu_idle && prev_alu_idle) begin
                launch_cyc = cyc;
                held       = {bus.o_alu_a, bus.o_alu_b, bus.o_alu_op};
                hold_ok    = 1'b1;
            end else if (!alu_idle && ({bus.o_alu_a, bus.o_alu_b, bus.o_alu_op} != held)) begin
                hold_ok = 1'b0;
            end
            prev_alu_idle = alu_idle;

            if (bus.o_res_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_response: got tag %0d, expected no response", bus.o_res_tag);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("res_data", 64'(bus.o_res_data), 64'(e.data));
                    checkOutput("res_status", 64'(bus.o_res_status), 64'(e.status));
                    checkOutput("res_tag", 64'(bus.o_res_tag), 64'(e.tag));
                    checkOutput("latency", 64'(cyc - launch_cyc),
                                64'((e.op == OP_DIVIDE) ? DIV_LAT : ALU_LAT));
                    checkOutput("alu_hold", 64'(hold_ok), 64'd1);
                end
            end else if (prev_valid && !prev_ready) begin
                checkOutput("res_stable", 64'({bus.o_res_valid, bus.o_res_data, bus.o_res_status, bus.o_res_tag}),
                            64'({1'b1, prev_resp}));
            end
            prev_valid = bus.o_res_valid;
            prev_ready = bus.i_res_ready;
            prev_resp  = {bus.o_res_data, bus.o_res_status, bus.o_res_tag};
        end
    end

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic offerOnce(input logic [M-1:0] a, input logic [M-1:0] b, input logic [3:0] op,
                             output bit accepted);
        exp_t x;
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_a     = a;
        bus.i_cmd_b     = b;
        bus.i_cmd_op    = op;
        accepted        = bus.o_cmd_ready;
        @(posedge clk);
        #1;
        bus.i_cmd_valid = 1'b0;
        if (accepted) begin
            {x.status, x.data} = aluModel(a, b, op);
            x.tag = tag_model;
            x.op  = op;
            exp_q.push_back(x);
            tag_model = tag_model + 4'd1;
        end
    endtask

    task automatic applyStimulus(input logic [M-1:0] a, input logic [M-1:0] b, input logic [3:0] op);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 500) begin
            offerOnce(a, b, op, acc);
            n++;
        end
        if (!acc) checkOutput("cmd_accept_timeout", 64'(acc), 64'd1);
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.o_busy || bus.o_res_valid) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput({name, "_drain"}, 64'(n < 3000), 64'd1);
    endtask

    task automatic checkResetValues(input string name);
        checkOutput({name, "_res_valid"}, 64'(bus.o_res_valid), 64'd0);
        checkOutput({name, "_res_fields"}, 64'({bus.o_res_data, bus.o_res_status, bus.o_res_tag}), 64'd0);
        checkOutput({name, "_alu_ab"}, 64'({bus.o_alu_a, bus.o_alu_b}), 64'd0);
        checkOutput({name, "_alu_op"}, 64'(bus.o_alu_op), 64'd3);
        checkOutput({name, "_busy"}, 64'(bus.o_busy), 64'd0);
        checkOutput({name, "_cmd_ready"}, 64'(bus.o_cmd_ready), 64'd1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected completion before time 500000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit acc;
        int nacc;
        logic [3:0] rop;
        logic [M-1:0] rb;

        i_reset         = 1'b0;
        bus.i_cmd_valid = 1'b0;
        bus.i_cmd_a     = '0;
        bus.i_cmd_b     = '0;
        bus.i_cmd_op    = '0;
        ready_mode      = 1;
        repeat (3) @(posedge clk);
        #1;
        checkResetValues("in_reset");
        i_reset = 1'b1;
        @(posedge clk);
        #1;
        checkResetValues("after_reset");

        $display("[TB] directed: shift, divide, error cases");
        applyStimulus(32'h0000_00F0, 32'd4, OP_BITWISE_SHIFT);
        waitDrain("shift");
        applyStimulus(32'd100, 32'd7, OP_DIVIDE);
        waitDrain("divide");
        applyStimulus(32'd9, 32'd3, 4'b0111);
        applyStimulus(32'd5, 32'd0, OP_DIVIDE);
        waitDrain("errors");

        $display("[TB] backpressure and push at full");
        ready_mode = 0;
        @(posedge clk);
        #1;
        nacc = 0;
        for (int i = 0; i < 6; i++) begin
            offerOnce(32'h100 + 32'(i), 32'(i), 4'(i % 2), acc);
            if (acc) nacc++;
        end
        checkOutput("bp_accepted", 64'(nacc), 64'(DEPTH + 1));
        checkOutput("bp_cmd_ready", 64'(bus.o_cmd_ready), 64'd0);
        ready_mode = 1;
        offerOnce(32'h8000_0005, 32'd0, OP_ZM_TO_U2, acc);
        checkOutput("full_pushpop_rejected", 64'(acc), 64'd0);
        offerOnce(32'h8000_0005, 32'd0, OP_ZM_TO_U2, acc);
        checkOutput("push_after_pop", 64'(acc), 64'd1);
        waitDrain("backpressure");

        $display("[TB] randomized commands with random response ready");
        ready_mode = 2;
        for (int i = 0; i < 40; i++) begin
            rop = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            rb  = ($urandom_range(0, 7) == 0) ? '0 : ($urandom() >> $urandom_range(0, 28));
            applyStimulus($urandom() | 32'd1, rb, rop);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        ready_mode = 1;
        waitDrain("random");

        $display("[TB] reset during divide hold");
        applyStimulus(32'd1000, 32'd3, OP_DIVIDE);
        applyStimulus(32'd21, 32'd2, OP_BITWISE_SHIFT);
        applyStimulus(32'd22, 32'd3, OP_COMPARE_AS);
        repeat (8) @(posedge clk);
        #1;
        checkOutput("mid_divide_busy", 64'(bus.o_busy), 64'd1);
        i_reset = 1'b0;
        #1;
        checkResetValues("async_reset");
        exp_q.delete();
        tag_model = 4'd0;
        @(posedge clk);
        #1;
        i_reset = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        applyStimulus(32'h0000_0C00, 32'd8, OP_BITWISE_SHIFT);
        waitDrain("post_reset");
        checkOutput("queue_empty_at_end", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
